tlul_host_port: RTL and testbench

TileLink-UL initiator that turns a simple command/response handshake into A-channel Get/PutFullData/PutPartialData requests and D-channel responses. It sits between a local requester (DMA engine, debug bridge, test sequencer) and the TL-UL crossbar, where it drives peripheral slaves such as the watchdog and timers. It supports up to 2^TL_RS outstanding transactions, tagged by TL source ID and allocated lowest-free-first. Responses are returned in D-channel arrival order, carrying their tag.

---
 rtl/tlul_pkg.sv | 24 ++
 rtl/tlul_source_alloc.sv | 43 ++++
 rtl/tlul_host_port.sv | 173 +++++++++++++++++
 tb/tb_tlul_host_port.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// TL-UL opcode encodings and constants shared by the host port and its helpers.
package tlul_pkg;

  typedef enum logic [2:0] {
    TL_PUT_FULL    = 3'd0,
    TL_PUT_PARTIAL = 3'd1,
    TL_GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    TL_ACCESS_ACK      = 3'd0,
    TL_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  localparam int TL_SIZE_WORD = 2;

  // A word write with every byte enabled is a full put; anything narrower is partial.
  function automatic tl_a_op_e a_opcode_for(input logic write, input logic [3:0] mask);
    if (!write) return TL_GET;
    if (mask == 4'hF) return TL_PUT_FULL;
    return TL_PUT_PARTIAL;
  endfunction

endpackage

// File: rtl/tlul_source_alloc.sv
// Source-ID allocator: tracks in-flight IDs and offers the lowest free one.
module tlul_source_alloc #(
  parameter int RS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_i,
  input  logic                 clr_i,
  input  logic [RS-1:0]        clr_idx_i,
  output logic [RS-1:0]        free_idx_o,
  output logic                 full_o,
  output logic [(1<<RS)-1:0]   inflight_o
);

  localparam int N = 1 << RS;

  logic [N-1:0] inflight_q, inflight_d;

  // Lowest clear bit wins; scanning downward leaves the smallest index last.
  always_comb begin
    free_idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!inflight_q[i]) free_idx_o = RS'(i);
    end
  end

  // Set and clear never hit the same ID: a set bit is never the free index.
  always_comb begin
    inflight_d = inflight_q;
    if (set_i) inflight_d[free_idx_o] = 1'b1;
    if (clr_i) inflight_d[clr_idx_i] = 1'b0;
  end

  // In-flight vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight_q <= '0;
    else     inflight_q <= inflight_d;
  end

  assign full_o     = &inflight_q;
  assign inflight_o = inflight_q;

endmodule

// File: rtl/tlul_host_port.sv
// TL-UL initiator: command/response handshake to A/D channels with tagged outstanding requests.
module tlul_host_port
  import tlul_pkg::*;
#(
  parameter int TL_RS = 4,
  parameter int TL_SZ = 4,
  parameter int TL_AW = 32
) (
  input  logic              host_clock_i,
  input  logic              host_reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [TL_AW-1:0]  cmd_address_i,
  input  logic [31:0]       cmd_wdata_i,
  input  logic [3:0]        cmd_mask_i,
  output logic [TL_RS-1:0]  cmd_tag_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [TL_RS-1:0]  rsp_tag_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_error_o,
  output logic              proto_err_o,
  output logic [2:0]        host_a_opcode,
  output logic [2:0]        host_a_param,
  output logic [TL_SZ-1:0]  host_a_size,
  output logic [TL_RS-1:0]  host_a_source,
  output logic [TL_AW-1:0]  host_a_address,
  output logic [3:0]        host_a_mask,
  output logic [31:0]       host_a_data,
  output logic              host_a_corrupt,
  output logic              host_a_valid,
  input  logic              host_a_ready,
  input  logic [2:0]        host_d_opcode,
  input  logic [1:0]        host_d_param,
  input  logic [TL_SZ-1:0]  host_d_size,
  input  logic [TL_RS-1:0]  host_d_source,
  input  logic              host_d_denied,
  input  logic [31:0]       host_d_data,
  input  logic              host_d_corrupt,
  input  logic              host_d_valid,
  output logic              host_d_ready
);

  localparam int N = 1 << TL_RS;

  logic             a_valid_q, a_valid_d;
  logic [2:0]       a_opcode_q, a_opcode_d;
  logic [TL_RS-1:0] a_source_q, a_source_d;
  logic [TL_AW-1:0] a_address_q, a_address_d;
  logic [3:0]       a_mask_q, a_mask_d;
  logic [31:0]      a_data_q, a_data_d;
  logic             a_sized_q, a_sized_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [TL_RS-1:0] rsp_tag_q, rsp_tag_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_error_q, rsp_error_d;
  logic             proto_err_q, proto_err_d;

  logic [TL_RS-1:0] free_idx;
  logic             full;
  logic [N-1:0]     inflight;
  logic             cmd_accept, a_fire, d_fire, d_known;
  logic             unused_d_fields;

  assign unused_d_fields = ^{host_d_param, host_d_size, cmd_address_i[1:0]};

  assign cmd_ready_o  = (~a_valid_q | host_a_ready) & ~full;
  assign cmd_tag_o    = free_idx;
  assign cmd_accept   = cmd_valid_i & cmd_ready_o;
  assign a_fire       = a_valid_q & host_a_ready;
  assign host_d_ready = ~rsp_valid_q | rsp_ready_i;
  assign d_fire       = host_d_valid & host_d_ready;
  assign d_known      = inflight[host_d_source];

  tlul_source_alloc #(.RS(TL_RS)) u_alloc (
    .clk        (host_clock_i),
    .rst        (host_reset_i),
    .set_i      (cmd_accept),
    .clr_i      (d_fire & d_known),
    .clr_idx_i  (host_d_source),
    .free_idx_o (free_idx),
    .full_o     (full),
    .inflight_o (inflight)
  );

  // A-channel holding register: loads on accept, drains on fire, frozen while stalled.
  always_comb begin
    a_valid_d   = a_valid_q;
    a_opcode_d  = a_opcode_q;
    a_source_d  = a_source_q;
    a_address_d = a_address_q;
    a_mask_d    = a_mask_q;
    a_data_d    = a_data_q;
    a_sized_d   = a_sized_q;
    if (a_fire) a_valid_d = 1'b0;
    if (cmd_accept) begin
      a_valid_d   = 1'b1;
      a_opcode_d  = a_opcode_for(cmd_write_i, cmd_mask_i);
      a_source_d  = free_idx;
      a_address_d = {cmd_address_i[TL_AW-1:2], 2'b00};
      a_mask_d    = cmd_write_i ? cmd_mask_i : 4'hF;
      a_data_d    = cmd_wdata_i;
      a_sized_d   = 1'b1;
    end
  end

  // Single-entry response register; stray D beats only raise the sticky error.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    proto_err_d = proto_err_q;
    if (rsp_valid_q & rsp_ready_i) rsp_valid_d = 1'b0;
    if (d_fire & d_known) begin
      rsp_valid_d = 1'b1;
      rsp_tag_d   = host_d_source;
      rsp_rdata_d = (host_d_opcode == TL_ACCESS_ACK_DATA) ? host_d_data : 32'h0;
      rsp_error_d = host_d_denied | ((host_d_opcode == TL_ACCESS_ACK_DATA) & host_d_corrupt);
    end
    if (d_fire & ~d_known) proto_err_d = 1'b1;
  end

  // State registers for both channels.
  always_ff @(posedge host_clock_i or posedge host_reset_i) begin
    if (host_reset_i) begin
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
      a_sized_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_opcode_q  <= a_opcode_d;
      a_source_q  <= a_source_d;
      a_address_q <= a_address_d;
      a_mask_q    <= a_mask_d;
      a_data_q    <= a_data_d;
      a_sized_q   <= a_sized_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Size reads as zero out of reset, word-sized once any request has been loaded.
  assign host_a_size    = a_sized_q ? TL_SZ'(TL_SIZE_WORD) : '0;
  assign host_a_valid   = a_valid_q;
  assign host_a_opcode  = a_opcode_q;
  assign host_a_param   = 3'd0;
  assign host_a_source  = a_source_q;
  assign host_a_address = a_address_q;
  assign host_a_mask    = a_mask_q;
  assign host_a_data    = a_data_q;
  assign host_a_corrupt = 1'b0;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_tag_o      = rsp_tag_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign rsp_error_o    = rsp_error_q;
  assign proto_err_o    = proto_err_q;

endmodule

// File: tb/tb_tlul_host_port.sv
// Directed bench for tlul_host_port with four source IDs.
module tb_tlul_host_port;

  localparam int RS = 2;
  localparam int SZ = 4;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_address = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0] cmd_mask = '0;
  logic [RS-1:0] cmd_tag;
  logic rsp_valid, rsp_ready = 1'b1, rsp_error, proto_err;
  logic [RS-1:0] rsp_tag;
  logic [31:0] rsp_rdata;
  logic [2:0] a_opcode, a_param;
  logic [SZ-1:0] a_size;
  logic [RS-1:0] a_source;
  logic [AW-1:0] a_address;
  logic [3:0] a_mask;
  logic [31:0] a_data;
  logic a_corrupt, a_valid, a_ready = 1'b1;
  logic [2:0] d_opcode = '0;
  logic [1:0] d_param = '0;
  logic [SZ-1:0] d_size = '0;
  logic [RS-1:0] d_source = '0;
  logic d_denied = 1'b0, d_corrupt = 1'b0, d_valid = 1'b0, d_ready;
  logic [31:0] d_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlul_host_port #(.TL_RS(RS), .TL_SZ(SZ), .TL_AW(AW)) dut (
    .host_clock_i(clk), .host_reset_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_address_i(cmd_address), .cmd_wdata_i(cmd_wdata), .cmd_mask_i(cmd_mask),
    .cmd_tag_o(cmd_tag),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_tag_o(rsp_tag),
    .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error), .proto_err_o(proto_err),
    .host_a_opcode(a_opcode), .host_a_param(a_param), .host_a_size(a_size),
    .host_a_source(a_source), .host_a_address(a_address), .host_a_mask(a_mask),
    .host_a_data(a_data), .host_a_corrupt(a_corrupt), .host_a_valid(a_valid),
    .host_a_ready(a_ready),
    .host_d_opcode(d_opcode), .host_d_param(d_param), .host_d_size(d_size),
    .host_d_source(d_source), .host_d_denied(d_denied), .host_d_data(d_data),
    .host_d_corrupt(d_corrupt), .host_d_valid(d_valid), .host_d_ready(d_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] m);
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr; cmd_wdata = wd; cmd_mask = m;
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [RS-1:0] src, input logic [31:0] dat,
                         input logic den, input logic cor);
    d_valid = 1'b1; d_opcode = op; d_source = src; d_data = dat; d_denied = den; d_corrupt = cor;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0; d_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt} !== '0) begin
      errors++; $display("FAIL reset_a_fields got valid=%b op=%h addr=%h mask=%h data=%h exp all zero",
                         a_valid, a_opcode, a_address, a_mask, a_data);
    end
    checks++;
    if ({rsp_valid, rsp_tag, rsp_rdata, rsp_error, proto_err} !== '0) begin
      errors++; $display("FAIL reset_rsp got valid=%b tag=%h rdata=%h err=%b proto=%b exp zeros",
                         rsp_valid, rsp_tag, rsp_rdata, rsp_error, proto_err);
    end
    checks++;
    if (cmd_ready !== 1'b1 || cmd_tag !== 2'd0 || d_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got cmd_ready=%b tag=%0d d_ready=%b exp 1 0 1",
                         cmd_ready, cmd_tag, d_ready);
    end
  endtask

  task automatic test_read();
    @(negedge clk);
    drive_cmd(1'b0, 32'h1000_0004, 32'h0, 4'h0);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || cmd_tag !== 2'd0) begin
      errors++; $display("FAIL read_accept got ready=%b tag=%0d exp 1 0", cmd_ready, cmd_tag);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (a_valid !== 1'b1 || a_opcode !== 3'd4 || a_address !== 32'h1000_0004 || a_mask !== 4'hF ||
        a_source !== 2'd0 || a_size !== 4'd2 || a_param !== 3'd0 || a_corrupt !== 1'b0) begin
      errors++; $display("FAIL read_a_beat got v=%b op=%0d addr=%h mask=%h src=%0d size=%0d exp 1 4 10000004 f 0 2",
                         a_valid, a_opcode, a_address, a_mask, a_source, a_size);
    end
    @(negedge clk);
    drive_d(3'd1, 2'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    d_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 2'd0 || rsp_rdata !== 32'hDEAD_BEEF || rsp_error !== 1'b0) begin
      errors++; $display("FAIL read_rsp got v=%b tag=%0d rdata=%h err=%b exp 1 0 deadbeef 0",
                         rsp_valid, rsp_tag, rsp_rdata, rsp_error);
    end
    checks++;
    if (a_valid !== 1'b0) begin
      errors++; $display("FAIL read_a_drained got a_valid=%b exp 0", a_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL read_rsp_consumed got rsp_valid=%b exp 0", rsp_valid);
    end
  endtask

  task automatic test_writes();
    @(negedge clk);
    drive_cmd(1'b1, 32'h2000_0006, 32'h0000_1234, 4'b0011);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (a_opcode !== 3'd1 || a_mask !== 4'h3 || a_data !== 32'h1234 || a_address !== 32'h2000_0004 ||
        a_source !== 2'd0) begin
      errors++; $display("FAIL partial_a_beat got op=%0d mask=%h data=%h addr=%h src=%0d exp 1 3 1234 20000004 0",
                         a_opcode, a_mask, a_data, a_address, a_source);
    end
    @(negedge clk);
    drive_d(3'd0, 2'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    d_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0 || rsp_tag !== 2'd0) begin
      errors++; $display("FAIL partial_rsp got v=%b err=%b rdata=%h tag=%0d exp 1 1 0 0",
                         rsp_valid, rsp_error, rsp_rdata, rsp_tag);
    end
    @(negedge clk);
    drive_cmd(1'b1, 32'h2000_0010, 32'hCAFE_F00D, 4'hF);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (a_opcode !== 3'd0 || a_mask !== 4'hF || a_data !== 32'hCAFE_F00D || a_source !== 2'd0) begin
      errors++; $display("FAIL full_a_beat got op=%0d mask=%h data=%h src=%0d exp 0 f cafef00d 0",
                         a_opcode, a_mask, a_data, a_source);
    end
    @(negedge clk);
    drive_d(3'd0, 2'd0, 32'h5555_5555, 1'b0, 1'b1);
    tick();
    d_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL ack_corrupt_ignored got v=%b err=%b rdata=%h exp 1 0 0",
                         rsp_valid, rsp_error, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_cmd(1'b0, 32'h3000_0000 + 32'(i * 4), 32'h0, 4'h0);
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || cmd_tag !== RS'(i)) begin
        errors++; $display("FAIL fill_tag_%0d got ready=%b tag=%0d exp 1 %0d", i, cmd_ready, cmd_tag, i);
      end
      if (i > 0) begin
        checks++;
        if (a_valid !== 1'b1 || a_source !== RS'(i - 1)) begin
          errors++; $display("FAIL fill_a_beat_%0d got v=%b src=%0d exp 1 %0d", i, a_valid, a_source, i - 1);
        end
      end
    end
    @(negedge clk);
    drive_d(3'd0, 2'd2, 32'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full_ready got %b exp 0", cmd_ready);
    end
    @(negedge clk);
    d_valid = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || cmd_tag !== 2'd2) begin
      errors++; $display("FAIL fill_reuse got ready=%b tag=%0d exp 1 2", cmd_ready, cmd_tag);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || a_source !== 2'd2) begin
      errors++; $display("FAIL fill_refull got ready=%b a_src=%0d exp 0 2", cmd_ready, a_source);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_d(3'd0, RS'(i), 32'h0, 1'b0, 1'b0);
    end
    @(negedge clk);
    d_valid = 1'b0;
    tick();
    checks++;
    if (proto_err !== 1'b0 || cmd_ready !== 1'b1 || cmd_tag !== 2'd0) begin
      errors++; $display("FAIL fill_drain got proto=%b ready=%b tag=%0d exp 0 1 0", proto_err, cmd_ready, cmd_tag);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    a_ready = 1'b0;
    drive_cmd(1'b0, 32'h3000_0008, 32'h0, 4'h0);
    tick();
    drive_cmd(1'b1, 32'h4000_0000, 32'h7777_7777, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0 || a_valid !== 1'b1 || a_address !== 32'h3000_0008 ||
          a_opcode !== 3'd4 || a_source !== 2'd0) begin
        errors++; $display("FAIL stall_hold_%0d got ready=%b v=%b addr=%h op=%0d src=%0d exp 0 1 30000008 4 0",
                           i, cmd_ready, a_valid, a_address, a_opcode, a_source);
      end
    end
    @(negedge clk);
    a_ready = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || cmd_tag !== 2'd1) begin
      errors++; $display("FAIL stall_release got ready=%b tag=%0d exp 1 1", cmd_ready, cmd_tag);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (a_valid !== 1'b1 || a_address !== 32'h4000_0000 || a_opcode !== 3'd0 || a_source !== 2'd1) begin
      errors++; $display("FAIL stall_next_beat got v=%b addr=%h op=%0d src=%0d exp 1 40000000 0 1",
                         a_valid, a_address, a_opcode, a_source);
    end
    @(negedge clk);
    drive_d(3'd1, 2'd0, 32'h1, 1'b0, 1'b0);
    @(negedge clk);
    drive_d(3'd0, 2'd1, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    d_valid = 1'b0;
    tick();
  endtask

  task automatic test_rsp_backpressure();
    @(negedge clk);
    drive_cmd(1'b0, 32'h5000_0000, 32'h0, 4'h0);
    @(negedge clk);
    drive_cmd(1'b0, 32'h5000_0004, 32'h0, 4'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    drive_d(3'd1, 2'd0, 32'hAAAA_0000, 1'b0, 1'b0);
    @(negedge clk);
    drive_d(3'd1, 2'd1, 32'hBBBB_1111, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (d_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_tag !== 2'd0 || rsp_rdata !== 32'hAAAA_0000) begin
        errors++; $display("FAIL bp_hold_%0d got d_ready=%b v=%b tag=%0d rdata=%h exp 0 1 0 aaaa0000",
                           i, d_ready, rsp_valid, rsp_tag, rsp_rdata);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (d_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready got %b exp 1", d_ready);
    end
    tick();
    d_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 2'd1 || rsp_rdata !== 32'hBBBB_1111 || rsp_error !== 1'b1) begin
      errors++; $display("FAIL bp_second got v=%b tag=%0d rdata=%h err=%b exp 1 1 bbbb1111 1",
                         rsp_valid, rsp_tag, rsp_rdata, rsp_error);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drained got rsp_valid=%b exp 0", rsp_valid);
    end
  endtask

  task automatic test_protocol();
    @(negedge clk);
    drive_d(3'd1, 2'd3, 32'h1357_9BDF, 1'b0, 1'b0);
    #1;
    checks++;
    if (d_ready !== 1'b1) begin
      errors++; $display("FAIL proto_consumed got d_ready=%b exp 1", d_ready);
    end
    tick();
    d_valid = 1'b0;
    checks++;
    if (proto_err !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL proto_raise got proto=%b rsp_valid=%b exp 1 0", proto_err, rsp_valid);
    end
    checks++;
    if (cmd_tag !== 2'd0) begin
      errors++; $display("FAIL proto_inflight got tag=%0d exp 0", cmd_tag);
    end
    tick(); tick(); tick();
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("FAIL proto_sticky got %b exp 1", proto_err);
    end
    @(negedge clk);
    drive_cmd(1'b0, 32'h6000_0000, 32'h0, 4'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    do_reset();
    #1;
    checks++;
    if (proto_err !== 1'b0 || a_valid !== 1'b0 || cmd_tag !== 2'd0) begin
      errors++; $display("FAIL proto_reset got proto=%b a_valid=%b tag=%0d exp 0 0 0", proto_err, a_valid, cmd_tag);
    end
    @(negedge clk);
    drive_d(3'd1, 2'd0, 32'h2468_ACE0, 1'b0, 1'b0);
    tick();
    d_valid = 1'b0;
    checks++;
    if (proto_err !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL proto_late_beat got proto=%b rsp_valid=%b exp 1 0", proto_err, rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_writes();
    test_fill();
    test_stall();
    test_rsp_backpressure();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
